// File: rtl/gcd_pkg.sv
// Shared types and constants for the iterative GCD responder.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int GCD_WIDTH = 16;  // default operand/result width
  localparam int CYC_W     = 16;  // iteration counter width

endpackage

// File: rtl/gcd_step.sv
// One subtract-GCD step as pure combinational logic.
// finish flags that one operand is zero; result is then the other operand.
module gcd_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_a,
  output logic [WIDTH-1:0] next_b,
  output logic             finish,
  output logic [WIDTH-1:0] result
);

  // Priority: a==0, b==0, a>b, else. Subtraction never wraps.
  always_comb begin
    next_a = a;
    next_b = b;
    finish = 1'b0;
    result = a;
    if (a == '0) begin
      finish = 1'b1;
      result = b;
    end else if (b == '0) begin
      finish = 1'b1;
      result = a;
    end else if (a > b) begin
      next_a = a - b;
    end else begin
      next_b = b - a;
    end
  end

endmodule

// File: rtl/gcd_responder.sv
// Iterative subtract-based GCD engine with load strobe and valid flag.
// Optional: define GCD_CYCLES_EN to add the io_cycles iteration counter port.
module gcd_responder
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_e,
  output logic [WIDTH-1:0] io_z,
  output logic             io_v
`ifdef GCD_CYCLES_EN
  ,
  output logic [CYC_W-1:0] io_cycles
`endif
);

  state_t           state;
  logic [WIDTH-1:0] a, b, z;
  logic [WIDTH-1:0] next_a, next_b, result;
  logic             finish;
  logic             load;

  // Loads are only accepted when not computing.
  assign load = io_e && (state == IDLE || state == DONE);
  assign io_z = z;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a      (a),
    .b      (b),
    .next_a (next_a),
    .next_b (next_b),
    .finish (finish),
    .result (result)
  );

  // Main FSM; io_v is registered one cycle behind entry into DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      z     <= '0;
      io_v  <= 1'b0;
    end else begin
      io_v <= 1'b0;
      case (state)
        IDLE: begin
          if (io_e) begin
            a     <= io_a;
            b     <= io_b;
            state <= CALC;
          end
        end
        CALC: begin
          if (finish) begin
            z     <= result;
            state <= DONE;
          end else begin
            a <= next_a;
            b <= next_b;
          end
        end
        DONE: begin
          if (io_e) begin
            a     <= io_a;
            b     <= io_b;
            state <= CALC;
          end else begin
            io_v <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_CYCLES_EN
  // Iteration counter: clears on load, counts CALC cycles, saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_cycles <= '0;
    end else if (load) begin
      io_cycles <= '0;
    end else if (state == CALC && io_cycles != {CYC_W{1'b1}}) begin
      io_cycles <= io_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_responder.sv
// Scoreboard bench for gcd_responder: stimulus pushes expected results,
// a negedge monitor pops and checks on every io_v rising edge.
module tb_gcd_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] io_a, io_b, io_z;
  logic        io_e, io_v;
`ifdef GCD_CYCLES_EN
  logic [15:0] io_cycles;
`endif

  typedef struct {
    logic [15:0] z;
    logic [15:0] cyc;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_run  = 0;
  int   n_fail = 0;
  int   edge_count = 0;
  logic prev_v = 1'b0;

  gcd_responder #(.WIDTH(16)) dut (
    .clock (clk),
    .reset (reset),
    .io_a  (io_a),
    .io_b  (io_b),
    .io_e  (io_e),
    .io_z  (io_z),
    .io_v  (io_v)
`ifdef GCD_CYCLES_EN
    ,
    .io_cycles (io_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare on each rising edge of io_v.
  always @(negedge clk) begin
    if (io_v && !prev_v) begin
      if (sb.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL spurious_valid: io_v rose with z=%0d, nothing expected", io_z);
      end else begin
        e = sb.pop_front();
        chk("result_z", {16'd0, io_z}, {16'd0, e.z});
        chk("valid_latency_edge", edge_count, e.due);
`ifdef GCD_CYCLES_EN
        chk("cycles", {16'd0, io_cycles}, {16'd0, e.cyc});
`endif
      end
    end
    prev_v = io_v;
  end

  // Issue a load; k = CALC cycles, io_v expected high after edge N+k+1.
  task automatic load(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] zexp, input logic [15:0] cexp, input int k);
    @(negedge clk);
    io_a = a; io_b = b; io_e = 1'b1;
    sb.push_back('{zexp, cexp, edge_count + 1 + k + 1});
    @(negedge clk);
    io_e = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 70000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; io_e = 1'b0; io_a = '0; io_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_v", {31'd0, io_v}, 32'd0);
      chk("idle_z", {16'd0, io_z}, 32'd0);
    end

    load(16'd12, 16'd8, 16'd4, 16'd4, 4);           wait_done();
    load(16'd0,  16'd0, 16'd0, 16'd1, 1);           wait_done();
    load(16'd0,  16'd9, 16'd9, 16'd1, 1);           wait_done();
    load(16'd9,  16'd0, 16'd9, 16'd1, 1);           wait_done();
    load(16'd1,  16'hFFFF, 16'd1, 16'hFFFF, 65536); wait_done();

    // Mid-CALC load pulse must be ignored
    load(16'd48, 16'd18, 16'd6, 16'd6, 6);
    @(negedge clk);
    io_a = 16'd5; io_b = 16'd5; io_e = 1'b1;
    @(negedge clk);
    io_e = 1'b0;
    wait_done();

    // Back-to-back load from DONE: io_v drops on the load edge
    chk("done_v_high", {31'd0, io_v}, 32'd1);
    @(negedge clk);
    io_a = 16'd35; io_b = 16'd21; io_e = 1'b1;
    sb.push_back('{16'd7, 16'd5, edge_count + 1 + 5 + 1});
    @(negedge clk);
    io_e = 1'b0;
    chk("b2b_v_fall", {31'd0, io_v}, 32'd0);
    wait_done();

    // Reset mid-CALC discards the computation
    @(negedge clk);
    io_a = 16'd100; io_b = 16'd1; io_e = 1'b1;
    @(negedge clk);
    io_e = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_v", {31'd0, io_v}, 32'd0);
    chk("rst_mid_z", {16'd0, io_z}, 32'd0);

    // Reset wins over a simultaneous load
    reset = 1'b1; io_e = 1'b1; io_a = 16'd0; io_b = 16'd0;
    @(negedge clk);
    reset = 1'b0; io_e = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_wins_v", {31'd0, io_v}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
